alu_share_arbiter: RTL and testbench

//  Shares the single 8-bit ALU between two requesters, e.g. the instruction datapath and a debug/DMA port.

---
 rtl/alu_share_arbiter_if.sv | 42 ++++
 rtl/alu_share_arbiter.sv | 98 +++++++++
 tb/tb_alu_share_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Bundle between two ALU requesters, the sharing arbiter and the ALU itself.
// The slave modport is the arbiter's view; master is the requester/ALU side.
interface alu_share_arbiter_if;
  logic       req0;
  logic [7:0] op0_a;
  logic [7:0] op0_b;
  logic [2:0] op0_sel;
  logic       req1;
  logic [7:0] op1_a;
  logic [7:0] op1_b;
  logic [2:0] op1_sel;
  logic       gnt0;
  logic       gnt1;
  logic       done0;
  logic       done1;
  logic [7:0] res_out;
  logic       zero_out;
  logic       busy;
  logic [7:0] alu_data1;
  logic [7:0] alu_data2;
  logic [2:0] alu_select;
  logic [7:0] alu_result;
  logic       alu_zero;

  modport slave (
    input  req0, op0_a, op0_b, op0_sel,
    input  req1, op1_a, op1_b, op1_sel,
    input  alu_result, alu_zero,
    output gnt0, gnt1, done0, done1,
    output res_out, zero_out, busy,
    output alu_data1, alu_data2, alu_select
  );

  modport master (
    output req0, op0_a, op0_b, op0_sel,
    output req1, op1_a, op1_b, op1_sel,
    output alu_result, alu_zero,
    input  gnt0, gnt1, done0, done1,
    input  res_out, zero_out, busy,
    input  alu_data1, alu_data2, alu_select
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one 8-bit ALU between two requesters: latch the winner's
// operands, wait WAIT_CYCLES edges for the ALU to settle, then return the result.
module alu_share_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1  // legal 1..15; must cover the ALU add delay
) (
  input logic                clk_i,
  input logic                reset_i,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       last_q;  // requester granted most recently; also owner of the op in flight
  logic       gnt0_q, gnt1_q, done0_q, done1_q, busy_q;
  logic [7:0] res_q;
  logic       zero_q;
  logic [7:0] data1_q, data2_q;
  logic [2:0] sel_q;

  logic       accept_d;
  logic       win1_d;

  // NOTE: every variable gets a default first so this block never infers a latch.
  always_comb begin
    accept_d = bus.req0 | bus.req1;
    win1_d   = bus.req1;
    if (bus.req0 && bus.req1) win1_d = ~last_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      data1_q <= '0;
      data2_q <= '0;
      sel_q   <= '0;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            data1_q <= win1_d ? bus.op1_a   : bus.op0_a;
            data2_q <= win1_d ? bus.op1_b   : bus.op0_b;
            sel_q   <= win1_d ? bus.op1_sel : bus.op0_sel;
            gnt0_q  <= ~win1_d;
            gnt1_q  <= win1_d;
            last_q  <= win1_d;
            cnt_q   <= WAIT_CYCLES[3:0];
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            res_q   <= bus.alu_result;
            zero_q  <= bus.alu_zero;
            done0_q <= ~last_q;
            done1_q <= last_q;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt0       = gnt0_q;
  assign bus.gnt1       = gnt1_q;
  assign bus.done0      = done0_q;
  assign bus.done1      = done1_q;
  assign bus.busy       = busy_q;
  assign bus.res_out    = res_q;
  assign bus.zero_out   = zero_q;
  assign bus.alu_data1  = data1_q;
  assign bus.alu_data2  = data2_q;
  assign bus.alu_select = sel_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: two instances (WAIT_CYCLES 1 and 3), each wired to a
// behavioural ALU; directed tables, hand sequences and a timestamp-based random model.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_share_arbiter_if bus_a ();
  alu_share_arbiter_if bus_b ();

  alu_share_arbiter #(.WAIT_CYCLES(1)) dut_a (.clk_i(clk), .reset_i(rst), .bus(bus_a));
  alu_share_arbiter #(.WAIT_CYCLES(3)) dut_b (.clk_i(clk), .reset_i(rst), .bus(bus_b));

  // Index 0 drives dut_a, index 1 drives dut_b.
  logic       req0_v[2], req1_v[2];
  logic [7:0] a0_v[2], b0_v[2], a1_v[2], b1_v[2];
  logic [2:0] s0_v[2], s1_v[2];

  assign bus_a.req0 = req0_v[0];  assign bus_b.req0 = req0_v[1];
  assign bus_a.op0_a = a0_v[0];   assign bus_b.op0_a = a0_v[1];
  assign bus_a.op0_b = b0_v[0];   assign bus_b.op0_b = b0_v[1];
  assign bus_a.op0_sel = s0_v[0]; assign bus_b.op0_sel = s0_v[1];
  assign bus_a.req1 = req1_v[0];  assign bus_b.req1 = req1_v[1];
  assign bus_a.op1_a = a1_v[0];   assign bus_b.op1_a = a1_v[1];
  assign bus_a.op1_b = b1_v[0];   assign bus_b.op1_b = b1_v[1];
  assign bus_a.op1_sel = s1_v[0]; assign bus_b.op1_sel = s1_v[1];

  // Behavioural ALU: 000 forward DATA2, 001 add, 010 and, 011 or, 100 add with zero flag.
  function automatic logic [8:0] alu_fn(input logic [7:0] d1, input logic [7:0] d2,
                                        input logic [2:0] s);
    logic [7:0] r;
    logic       z;
    r = 8'h00;
    z = 1'b0;
    case (s)
      3'b000: r = d2;
      3'b001: r = d1 + d2;
      3'b010: r = d1 & d2;
      3'b011: r = d1 | d2;
      3'b100: begin r = d1 + d2; z = (r == 8'h00); end
      default: r = 8'h00;
    endcase
    return {z, r};
  endfunction

  assign {bus_a.alu_zero, bus_a.alu_result} = alu_fn(bus_a.alu_data1, bus_a.alu_data2, bus_a.alu_select);
  assign {bus_b.alu_zero, bus_b.alu_result} = alu_fn(bus_b.alu_data1, bus_b.alu_data2, bus_b.alu_select);

  typedef struct packed {
    logic       gnt0, gnt1, done0, done1, busy, zero;
    logic [7:0] res, d1, d2;
    logic [2:0] sel;
  } obs_t;

  function automatic obs_t observe(input int k);
    obs_t o;
    if (k == 0)
      o = {bus_a.gnt0, bus_a.gnt1, bus_a.done0, bus_a.done1, bus_a.busy, bus_a.zero_out,
           bus_a.res_out, bus_a.alu_data1, bus_a.alu_data2, bus_a.alu_select};
    else
      o = {bus_b.gnt0, bus_b.gnt1, bus_b.done0, bus_b.done1, bus_b.busy, bus_b.zero_out,
           bus_b.res_out, bus_b.alu_data1, bus_b.alu_data2, bus_b.alu_select};
    return o;
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input bit who, input bit r, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] s);
    if (!who) begin
      req0_v[k] = r; a0_v[k] = a; b0_v[k] = b; s0_v[k] = s;
    end else begin
      req1_v[k] = r; a1_v[k] = a; b1_v[k] = b; s1_v[k] = s;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(k, 1'b0, 1'b0, 8'h00, 8'h00, 3'b000);
      drive(k, 1'b1, 1'b0, 8'h00, 8'h00, 3'b000);
    end
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    bit         who;
    logic [7:0] a, b;
    logic [2:0] sel;
    logic [7:0] exp_res;
    logic       exp_zero;
  } vec_t;

  vec_t vecs[11];

  // Random traffic against a model that only tracks accept timestamps and the round-robin pointer.
  task automatic random_run(input int k, input int w, input int cycles);
    int         acc;
    bit         last, owner;
    bit         rq[2];
    logic [7:0] ra[2], rb[2];
    logic [2:0] rs[2];
    logic [7:0] m_res, m_d1, m_d2;
    logic [2:0] m_sel;
    logic       m_zero;
    logic [8:0] zr;
    bit         eg[2];
    bit         ed[2];
    bit         eb, win;
    obs_t       o;
    acc = -1000; last = 1'b1; owner = 1'b0;
    m_res = '0; m_zero = 1'b0; m_d1 = '0; m_d2 = '0; m_sel = '0;
    for (int r = 0; r < 2; r++) begin rq[r] = 1'b0; ra[r] = '0; rb[r] = '0; rs[r] = '0; end
    for (int e = 1; e <= cycles; e++) begin
      for (int r = 0; r < 2; r++) begin
        if (!rq[r] && $urandom_range(0, 2) == 0) begin
          rq[r] = 1'b1;
          ra[r] = 8'($urandom); rb[r] = 8'($urandom); rs[r] = 3'($urandom_range(0, 7));
        end
        drive(k, r[0], rq[r], ra[r], rb[r], rs[r]);
      end
      eg[0] = 1'b0; eg[1] = 1'b0; ed[0] = 1'b0; ed[1] = 1'b0;
      if (e > acc + w && (rq[0] || rq[1])) begin
        win = (rq[0] && rq[1]) ? ~last : rq[1];
        acc = e; last = win; owner = win; eg[win] = 1'b1;
        m_d1 = ra[win]; m_d2 = rb[win]; m_sel = rs[win];
      end
      if (e == acc + w) begin
        ed[owner] = 1'b1;
        zr = alu_fn(m_d1, m_d2, m_sel);
        m_res = zr[7:0]; m_zero = zr[8];
      end
      eb = (acc <= e) && (e < acc + w);
      step();
      o = observe(k);
      check($sformatf("rnd%0d e%0d pulses", k, e), {o.gnt0, o.gnt1, o.done0, o.done1, o.busy},
            {eg[0], eg[1], ed[0], ed[1], eb});
      check($sformatf("rnd%0d e%0d result", k, e), {o.zero, o.res}, {m_zero, m_res});
      check($sformatf("rnd%0d e%0d alu_in", k, e), {o.d1, o.d2, o.sel}, {m_d1, m_d2, m_sel});
      for (int r = 0; r < 2; r++) begin
        if (eg[r]) begin
          if ($urandom_range(0, 3) == 0) begin
            ra[r] = 8'($urandom); rb[r] = 8'($urandom); rs[r] = 3'($urandom_range(0, 7));
          end else begin
            rq[r] = 1'b0;
          end
        end
      end
    end
    drive(k, 1'b0, 1'b0, 8'h00, 8'h00, 3'b000);
    drive(k, 1'b1, 1'b0, 8'h00, 8'h00, 3'b000);
  endtask

  initial begin
    obs_t       o;
    logic [4:0] exp6[8];

    vecs[0]  = '{1'b0, 8'h05, 8'h03, 3'b001, 8'h08, 1'b0};
    vecs[1]  = '{1'b0, 8'h07, 8'hF9, 3'b100, 8'h00, 1'b1};
    vecs[2]  = '{1'b0, 8'h07, 8'hF9, 3'b001, 8'h00, 1'b0};
    vecs[3]  = '{1'b1, 8'hF0, 8'h3C, 3'b010, 8'h30, 1'b0};
    vecs[4]  = '{1'b1, 8'h0F, 8'h30, 3'b011, 8'h3F, 1'b0};
    vecs[5]  = '{1'b0, 8'h12, 8'h34, 3'b101, 8'h00, 1'b0};
    vecs[6]  = '{1'b1, 8'hAA, 8'h55, 3'b111, 8'h00, 1'b0};
    vecs[7]  = '{1'b1, 8'h01, 8'hFF, 3'b100, 8'h00, 1'b1};
    vecs[8]  = '{1'b0, 8'h80, 8'h7F, 3'b100, 8'hFF, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 8'h5A, 3'b000, 8'h5A, 1'b0};
    vecs[10] = '{1'b1, 8'h33, 8'h44, 3'b110, 8'h00, 1'b0};

    // Reset: every output of both instances is zero.
    do_reset();
    check("reset dut_a", 64'(observe(0)), 64'd0);
    check("reset dut_b", 64'(observe(1)), 64'd0);

    // Single operations on the WAIT_CYCLES=1 instance.
    for (int i = 0; i < 11; i++) begin
      drive(0, vecs[i].who, 1'b1, vecs[i].a, vecs[i].b, vecs[i].sel);
      step();
      o = observe(0);
      check($sformatf("vec%0d gnt", i), {o.gnt0, o.gnt1, o.done0, o.done1, o.busy},
            {~vecs[i].who, vecs[i].who, 2'b00, 1'b1});
      check($sformatf("vec%0d alu_in", i), {o.d1, o.d2, o.sel}, {vecs[i].a, vecs[i].b, vecs[i].sel});
      drive(0, vecs[i].who, 1'b0, vecs[i].a, vecs[i].b, vecs[i].sel);
      step();
      o = observe(0);
      check($sformatf("vec%0d done", i), {o.gnt0, o.gnt1, o.done0, o.done1, o.busy},
            {2'b00, ~vecs[i].who, vecs[i].who, 1'b0});
      check($sformatf("vec%0d result", i), {o.zero, o.res}, {vecs[i].exp_zero, vecs[i].exp_res});
      step();
      o = observe(0);
      check($sformatf("vec%0d quiet", i), {o.gnt0, o.gnt1, o.done0, o.done1, o.busy}, 5'b00000);
    end

    // Both requesters held: grants alternate 0,1,0,1 starting with requester 0.
    do_reset();
    drive(0, 1'b0, 1'b1, 8'hF0, 8'h3C, 3'b010);
    drive(0, 1'b1, 1'b1, 8'h0F, 8'h30, 3'b011);
    for (int e = 1; e <= 8; e++) begin
      bit who;
      who = ((e - 1) / 2) % 2;
      step();
      o = observe(0);
      if (e % 2 == 1) begin
        check($sformatf("rr e%0d", e), {o.gnt0, o.gnt1, o.done0, o.done1}, {~who, who, 2'b00});
      end else begin
        check($sformatf("rr e%0d", e), {o.gnt0, o.gnt1, o.done0, o.done1}, {2'b00, ~who, who});
        check($sformatf("rr e%0d res", e), o.res, who ? 8'h3F : 8'h30);
      end
    end
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 3'b000);
    drive(0, 1'b1, 1'b0, 8'h00, 8'h00, 3'b000);
    step();

    // Reset during EXEC aborts the op; the following tie goes to requester 0 again.
    do_reset();
    drive(0, 1'b0, 1'b1, 8'h05, 8'h03, 3'b001);
    step();
    o = observe(0);
    check("abort gnt0", {o.gnt0, o.busy}, 2'b11);
    drive(0, 1'b0, 1'b0, 8'h05, 8'h03, 3'b001);
    rst = 1'b1;
    step();
    rst = 1'b0;
    o = observe(0);
    check("abort no done", 64'(o), 64'd0);
    drive(0, 1'b0, 1'b1, 8'h11, 8'h22, 3'b011);
    drive(0, 1'b1, 1'b1, 8'h44, 8'h88, 3'b011);
    step();
    o = observe(0);
    check("abort tie", {o.gnt0, o.gnt1, o.d1}, {2'b10, 8'h11});
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00, 3'b000);
    drive(0, 1'b1, 1'b0, 8'h00, 8'h00, 3'b000);
    step();
    o = observe(0);
    check("abort tie done", {o.done0, o.res}, {1'b1, 8'h33});
    step();

    // WAIT_CYCLES=3: DONE0 three edges after GNT0, GNT1 on the edge DONE0 falls.
    do_reset();
    exp6 = '{5'b10001, 5'b00001, 5'b00001, 5'b00100, 5'b01001, 5'b00001, 5'b00001, 5'b00010};
    drive(1, 1'b0, 1'b1, 8'hF0, 8'h3C, 3'b010);
    for (int e = 1; e <= 8; e++) begin
      step();
      o = observe(1);
      check($sformatf("w3 e%0d", e), {o.gnt0, o.gnt1, o.done0, o.done1, o.busy}, exp6[e-1]);
      if (e == 1) begin
        drive(1, 1'b0, 1'b0, 8'hF0, 8'h3C, 3'b010);
        drive(1, 1'b1, 1'b1, 8'h0F, 8'h30, 3'b011);
      end
      if (e == 4) check("w3 res0", o.res, 8'h30);
      if (e == 5) begin
        check("w3 alu_in1", {o.d1, o.d2, o.sel}, {8'h0F, 8'h30, 3'b011});
        drive(1, 1'b1, 1'b0, 8'h0F, 8'h30, 3'b011);
      end
      if (e == 8) check("w3 res1", o.res, 8'h3F);
    end

    // Random traffic on both instances.
    do_reset();
    random_run(0, 1, 400);
    do_reset();
    random_run(1, 3, 400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
